// File: rtl/mat4x2_2x2_seq_ctrl.sv
// rtl/mat4x2_2x2_seq_ctrl.sv - sequenced 4x2 by 2x2 nibble matrix product on one shared dot-product datapath
// Optional build macro: MAT_SEQ_PERF_CNT_EN adds done_cnt/stall_cnt outputs.
module mat4x2_2x2_seq_ctrl #(
    parameter int DW = 4,
    localparam int OW = 2*DW+1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [8*DW-1:0] a_in,
    input  logic [4*DW-1:0] b_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OW-1:0]   out_data,
    output logic [2:0]      out_idx,
    output logic            out_last,
    output logic            busy
`ifdef MAT_SEQ_PERF_CNT_EN
    ,
    output logic [15:0]     done_cnt,
    output logic [15:0]     stall_cnt
`endif
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state, state_nxt;
    logic [8*DW-1:0] a_reg, a_nxt;
    logic [4*DW-1:0] b_reg, b_nxt;
    logic            out_valid_nxt;
    logic [OW-1:0]   out_data_nxt;
    logic [2:0]      out_idx_nxt;
    logic            out_last_nxt;

    logic [8*DW-1:0] src_a;
    logic [4*DW-1:0] src_b;
    logic [2:0]      sel_idx;
    int              row_i;
    int              col_i;
    logic [DW-1:0]   a_e0, a_e1, b_e0, b_e1;
    logic [OW-1:0]   dot;
    logic            beat_acc;

    assign beat_acc = out_valid & out_ready;
    assign in_ready = (state == IDLE);
    assign busy     = (state == RUN);

    // In IDLE the datapath looks straight at the input bus so S0 is ready on the accept edge.
    always_comb begin
        src_a   = (state == IDLE) ? a_in : a_reg;
        src_b   = (state == IDLE) ? b_in : b_reg;
        sel_idx = (state == IDLE) ? 3'd0 : 3'(out_idx + 3'd1);
        row_i   = int'(sel_idx[2:1]);
        col_i   = int'(sel_idx[0]);
        a_e0    = src_a[2*DW*row_i +: DW];
        a_e1    = src_a[2*DW*row_i + DW +: DW];
        b_e0    = src_b[DW*col_i +: DW];
        b_e1    = src_b[DW*col_i + 2*DW +: DW];
        dot     = OW'(a_e0) * OW'(b_e0) + OW'(a_e1) * OW'(b_e1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= 3'd0;
            out_last  <= 1'b0;
        end else begin
            state     <= state_nxt;
            a_reg     <= a_nxt;
            b_reg     <= b_nxt;
            out_valid <= out_valid_nxt;
            out_data  <= out_data_nxt;
            out_idx   <= out_idx_nxt;
            out_last  <= out_last_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        a_nxt         = a_reg;
        b_nxt         = b_reg;
        out_valid_nxt = out_valid;
        out_data_nxt  = out_data;
        out_idx_nxt   = out_idx;
        out_last_nxt  = out_last;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    a_nxt         = a_in;
                    b_nxt         = b_in;
                    out_valid_nxt = 1'b1;
                    out_data_nxt  = dot;
                    out_idx_nxt   = 3'd0;
                    out_last_nxt  = 1'b0;
                    state_nxt     = RUN;
                end
            end
            RUN: begin
                if (beat_acc) begin
                    if (out_last) begin
                        out_valid_nxt = 1'b0;
                        out_last_nxt  = 1'b0;
                        state_nxt     = IDLE;
                    end else begin
                        out_data_nxt  = dot;
                        out_idx_nxt   = sel_idx;
                        out_last_nxt  = (sel_idx == 3'd7);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef MAT_SEQ_PERF_CNT_EN
    // done_cnt wraps, stall_cnt saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt  <= 16'd0;
            stall_cnt <= 16'd0;
        end else begin
            if (beat_acc && out_last)
                done_cnt <= done_cnt + 16'd1;
            if (out_valid && !out_ready && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mat4x2_2x2_seq_ctrl.sv
// tb/tb_mat4x2_2x2_seq_ctrl.sv - scoreboard bench for mat4x2_2x2_seq_ctrl
module tb_mat4x2_2x2_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a_in = '0;
    logic [15:0] b_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [8:0]  out_data;
    logic [2:0]  out_idx;
    logic        out_last;
    logic        busy;
`ifdef MAT_SEQ_PERF_CNT_EN
    logic [15:0] done_cnt;
    logic [15:0] stall_cnt;
`endif

    mat4x2_2x2_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
        .busy(busy)
`ifdef MAT_SEQ_PERF_CNT_EN
        , .done_cnt(done_cnt), .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] idx;
        logic [8:0] data;
        logic       last;
    } beat_t;

    beat_t sb[$];
    int n_checks = 0;
    int n_fail   = 0;

    // Hand-computed results: set 0 basic, set 1 all-15, set 2 A0=1/B0=5.
    logic [8:0] exp_tab[3][8] = '{
        '{9'd7, 9'd10, 9'd15, 9'd22, 9'd23, 9'd34, 9'd31, 9'd46},
        '{9'd450, 9'd450, 9'd450, 9'd450, 9'd450, 9'd450, 9'd450, 9'd450},
        '{9'd5, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0}
    };
    logic [31:0] a_tab[3] = '{32'h87654321, 32'hFFFFFFFF, 32'h00000001};
    logic [15:0] b_tab[3] = '{16'h4321, 16'hFFFF, 16'h0005};

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_set(input int s);
        for (int k = 0; k < 8; k++) begin
            beat_t b;
            b.idx  = 3'(k);
            b.data = exp_tab[s][k];
            b.last = (k == 7);
            sb.push_back(b);
        end
    endtask

    // Drives one set for a single cycle; returns at accept edge + 1.
    task automatic issue(input int s);
        int cnt = 0;
        while (!in_ready && cnt < 100) begin
            @(posedge clk); #1; cnt++;
        end
        if (cnt >= 100) check("issue_timeout", 0, 1);
        a_in = a_tab[s];
        b_in = b_tab[s];
        in_valid = 1'b1;
        push_set(s);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int cnt = 0;
        out_ready = 1'b1;
        while ((sb.size() != 0 || busy) && cnt < 200) begin
            @(posedge clk); #1; cnt++;
        end
        check("drain_done", (cnt < 200) ? 1 : 0, 1);
    endtask

    // Monitor: pops on each accepted beat and checks hold during stalls.
    logic       prev_stall = 1'b0;
    logic [8:0] prev_data;
    logic [2:0] prev_idx;
    always @(negedge clk) begin
        if (!rst_n || !out_valid) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_data", int'(out_data), int'(prev_data));
                check("hold_idx", int'(out_idx), int'(prev_idx));
            end
            if (out_ready) begin
                prev_stall = 1'b0;
                if (sb.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    check("beat_idx", int'(out_idx), int'(e.idx));
                    check("beat_data", int'(out_data), int'(e.data));
                    check("beat_last", int'(out_last), int'(e.last));
                end
            end else begin
                prev_stall = 1'b1;
                prev_data  = out_data;
                prev_idx   = out_idx;
            end
        end
    end

    initial begin
        int cnt;
`ifdef MAT_SEQ_PERF_CNT_EN
        int done_base;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_idx", int'(out_idx), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic with latency checks
        issue(0);
        check("lat_valid", int'(out_valid), 1);
        check("lat_busy", int'(busy), 1);
        check("lat_in_ready", int'(in_ready), 0);
        repeat (7) @(posedge clk);
        #1;
        check("lat_idx7", int'(out_idx), 7);
        check("lat_last", int'(out_last), 1);
        @(posedge clk); #1;
        check("end_in_ready", int'(in_ready), 1);
        check("end_out_valid", int'(out_valid), 0);
        check("end_busy", int'(busy), 0);

        // Max values
        issue(1);
        drain();

        // Backpressure at idx 2
        issue(0);
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bp_idx", int'(out_idx), 2);
            check("bp_data", int'(out_data), 15);
        end
        out_ready = 1'b1;
        drain();
`ifdef MAT_SEQ_PERF_CNT_EN
        check("stall_cnt", int'(stall_cnt), 3);
        check("done_cnt3", int'(done_cnt), 3);
        done_base = int'(done_cnt);
`endif

        // Back-to-back with in_valid held high
        a_in = a_tab[0];
        b_in = b_tab[0];
        in_valid = 1'b1;
        push_set(0);
        @(posedge clk); #1;
        a_in = a_tab[2];
        b_in = b_tab[2];
        push_set(2);
        cnt = 0;
        while (!in_ready && cnt < 50) begin
            @(posedge clk); #1; cnt++;
        end
        check("b2b_gap", cnt, 8);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("b2b_second_busy", int'(busy), 1);
        drain();
`ifdef MAT_SEQ_PERF_CNT_EN
        check("done_cnt_b2b", int'(done_cnt) - done_base, 2);
`endif

        // Input ignore during RUN
        issue(0);
        for (int i = 0; i < 3; i++) begin
            a_in = $urandom;
            b_in = 16'($urandom);
            in_valid = (i != 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        drain();
        repeat (3) @(posedge clk);
        #1;
        check("ignore_no_run", int'(out_valid), 0);
        check("ignore_idle", int'(in_ready), 1);

        // Reset mid-run at idx 4
        issue(0);
        repeat (4) @(posedge clk);
        #1;
        check("mid_idx4", int'(out_idx), 4);
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_in_ready", int'(in_ready), 1);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_data", int'(out_data), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_valid", int'(out_valid), 0);
        issue(0);
        drain();
        check("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
